fifo_fwft_block_checker: RTL
============================

Name: fifo_fwft_block_checker

Overview:
- Synthesizable successor to the bench-side FWFT FIFO reader. It drains a block of N words from a first-word-fall-through FIFO, throttled by a pseudo-random read rate.
- Each accepted word is checked against a generated expected pattern, and the block reports word count, error count and the first mismatch.
- Sits on the read side of the FIFO under test, in bench top-levels and in FPGA self-test builds.

Parameters:
- WIDTH, 8, data width of din and the pattern generator (>=1).
- MAX_BLOCK_SIZE, 1024, largest legal block_len. LW = $clog2(MAX_BLOCK_SIZE+1) is the width of all length/count ports.
- LFSR_SEED, 16'hACE1, reset/start value of the throttle LFSR. Must be nonzero.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- din  in  WIDTH  FIFO head word; valid whenever empty=0.
- empty  in  1  FIFO empty flag.
- rden  out  1  read strobe; the word is consumed at posedge when rden=1.
- start  in  1  one-cycle request to begin a block; sampled in IDLE/DONE only.
- block_len  in  LW  words to read; sampled with start.
- rate  in  8  read throttle: 0 = never read, 8'hFF = read every cycle.
- mode  in  1  expected pattern, sampled with start: 0 = binary count, 1 = Gray count.
- base  in  WIDTH  first value of the pattern counter, sampled with start.
- abort  in  1  terminate the block in progress.
- busy  out  1  state==READ.
- done  out  1  block completed, held until the next start.
- word_count  out  LW  words accepted in the current/last block.
- err_count  out  LW  mismatches, saturating at all-ones.
- first_err_idx  out  LW  index of the first mismatch (valid when err_count!=0).
- first_err_data  out  WIDTH  din value at the first mismatch.

Behaviour:
- Reset: state=IDLE, lfsr=LFSR_SEED, all outputs 0 (rden=0, busy=0, done=0, all counts and captures 0).
- States:
  - IDLE/DONE, start=1, block_len!=0: go to READ. Latch len, mode and pattern counter pc=base. Clear word_count, err_count, first_err_*. Set lfsr=LFSR_SEED, done=0.
  - IDLE/DONE, start=1, block_len=0: go to DONE next cycle with all counts 0.
  - READ, abort=1: go to IDLE next cycle. rden=0 in the abort cycle. Counts are retained; done stays 0.
- Throttle: 16-bit Fibonacci LFSR, taps 16,14,13,11. It shifts every cycle in READ and holds otherwise. allow = (rate==8'hFF) | (lfsr[7:0] < rate).
- Read strobe: rden = busy & ~empty & allow & ~abort. It is combinational from registered state and the empty/abort inputs. rden is never 1 while empty=1.
- Accept, on a posedge with rden=1:
  - expected = (mode ? pc ^ (pc>>1) : pc).
  - If din != expected: err_count += 1 (saturating). If this is the first mismatch, capture first_err_idx=word_count and first_err_data=din.
  - word_count += 1; pc += 1, wrapping mod 2^WIDTH.
- Completion: the accept that makes word_count==len sets state=DONE and done=1 on the same edge, and rden=0 from the next cycle. There is no over-read.
- Latency: the first rden can occur the cycle after start. Back-to-back accepts are allowed every cycle.
- start while busy: ignored. start and abort both high in IDLE: start wins.
- rst_n low mid-block: immediate return to reset values; the partial block is lost.

Test Plan:
- rate=FF, mode=0, base=0, block_len=16, FIFO preloaded 0..15 -> rden high 16 consecutive cycles, done=1, word_count=16, err_count=0, FIFO empty afterwards.
- rate=FF, mode=1, base=0, block_len=8, FIFO holds 0,1,3,2,6,7,5,4 -> err_count=0. Repeat with the 5th word corrupted to 8'h55 -> err_count=1, first_err_idx=4, first_err_data=8'h55.
- rate=8'h40, block_len=100, FIFO always non-empty with correct data -> done after ~400 cycles; rden duty ≈25% (±8%); err_count=0. Rerun gives an identical rden trace (deterministic seed).
- empty toggled randomly, rate=FF, block_len=MAX_BLOCK_SIZE, WIDTH=8 with base=8'hF0 -> never rden while empty, pattern wraps FF->00 cleanly, word_count=1024, err_count=0.
- abort asserted after 5 accepts of block_len=20 -> rden=0 in the abort cycle, busy=0 next cycle, word_count=5, done=0. Then start, block_len=0 -> done=1 after one cycle, word_count=0.
- rst_n pulled low during READ with words outstanding -> rden/busy/done/counts go 0 asynchronously. A subsequent start works normally.

Source files
------------

// File: rtl/fifo_fwft_block_checker.sv
// Read-side checker for a first-word-fall-through FIFO: drains a block of words
// at an LFSR-throttled rate and compares each word against a binary/Gray pattern.
module fifo_fwft_block_checker #(
  parameter int          WIDTH          = 8,
  parameter int          MAX_BLOCK_SIZE = 1024,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  localparam int         LW             = $clog2(MAX_BLOCK_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             empty,
  output logic             rden,
  input  logic             start,
  input  logic [LW-1:0]    block_len,
  input  logic [7:0]       rate,
  input  logic             mode,
  input  logic [WIDTH-1:0] base,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [LW-1:0]    word_count,
  output logic [LW-1:0]    err_count,
  output logic [LW-1:0]    first_err_idx,
  output logic [WIDTH-1:0] first_err_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DONE} state_t;

  localparam logic [LW-1:0]    LW_ONE = LW'(1);
  localparam logic [WIDTH-1:0] PC_ONE = WIDTH'(1);

  state_t           r_state;
  state_t           w_state_next;
  logic [15:0]      r_lfsr;
  logic [LW-1:0]    r_len;
  logic             r_mode;
  logic [WIDTH-1:0] r_pc;
  logic [LW-1:0]    r_word_count;
  logic [LW-1:0]    r_err_count;
  logic [LW-1:0]    r_first_err_idx;
  logic [WIDTH-1:0] r_first_err_data;

  logic             w_busy;
  logic             w_allow;
  logic             w_rden;
  logic             w_start;
  logic             w_last;
  logic             w_mismatch;
  logic [WIDTH-1:0] w_expected;
  logic [LW-1:0]    w_wc_inc;
  logic [15:0]      w_lfsr_next;

  // Right-shifting Fibonacci form, taps 16,14,13,11 (bits 0,2,3,5 feed bit 15).
  assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};

  assign w_busy     = (r_state == ST_READ);
  assign w_allow    = (rate == 8'hFF) || (r_lfsr[7:0] < rate);
  assign w_rden     = w_busy & ~empty & w_allow & ~abort;
  assign w_start    = start & ~w_busy;
  assign w_expected = r_mode ? (r_pc ^ (r_pc >> 1)) : r_pc;
  assign w_mismatch = (din != w_expected);
  assign w_wc_inc   = r_word_count + LW_ONE;
  assign w_last     = (w_wc_inc == r_len);

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: the default first keeps every path assigned, so no latch is inferred.
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_state_next = (block_len == '0) ? ST_DONE : ST_READ;
      end
      ST_READ: begin
        if (abort)                w_state_next = ST_IDLE;
        else if (w_rden && w_last) w_state_next = ST_DONE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr           <= LFSR_SEED;
      r_len            <= '0;
      r_mode           <= 1'b0;
      r_pc             <= '0;
      r_word_count     <= '0;
      r_err_count      <= '0;
      r_first_err_idx  <= '0;
      r_first_err_data <= '0;
    end else if (w_start) begin
      r_lfsr           <= LFSR_SEED;
      r_len            <= block_len;
      r_mode           <= mode;
      r_pc             <= base;
      r_word_count     <= '0;
      r_err_count      <= '0;
      r_first_err_idx  <= '0;
      r_first_err_data <= '0;
    end else if (w_busy) begin
      r_lfsr <= w_lfsr_next;
      if (w_rden) begin
        // The capture tests the pre-increment count, so only the first miss is kept.
        if (w_mismatch) begin
          if (r_err_count == '0) begin
            r_first_err_idx  <= r_word_count;
            r_first_err_data <= din;
          end
          if (r_err_count != '1) r_err_count <= r_err_count + LW_ONE;
        end
        r_word_count <= w_wc_inc;
        r_pc         <= r_pc + PC_ONE;
      end
    end
  end

  assign rden           = w_rden;
  assign busy           = w_busy;
  assign done           = (r_state == ST_DONE);
  assign word_count     = r_word_count;
  assign err_count      = r_err_count;
  assign first_err_idx  = r_first_err_idx;
  assign first_err_data = r_first_err_data;

endmodule
